// File: rtl/cond_flag_register_if.sv
// rtl/cond_flag_register_if.sv - execute-stage predication bus between pipeline control and flag register
interface cond_flag_register_if #(
  parameter int CNT_W = 16
);
  logic             valid;
  logic             stall;
  logic             flush;
  logic             cond_ex;
  logic [1:0]       flag_w;
  logic [1:0]       alu_flag_a;
  logic [1:0]       alu_flag_b;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             cnt_clr;
  logic [1:0]       flag_a;
  logic [1:0]       flag_b;
  logic             pc_src_e;
  logic             pc_src_m;
  logic             reg_write_m;
  logic             mem_write_m;
  logic             valid_m;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output valid, stall, flush, cond_ex, flag_w, alu_flag_a, alu_flag_b,
           pcs, reg_w, mem_w, cnt_clr,
    input  flag_a, flag_b, pc_src_e, pc_src_m, reg_write_m, mem_write_m,
           valid_m, exec_cnt, squash_cnt
  );

  modport slave (
    input  valid, stall, flush, cond_ex, flag_w, alu_flag_a, alu_flag_b,
           pcs, reg_w, mem_w, cnt_clr,
    output flag_a, flag_b, pc_src_e, pc_src_m, reg_write_m, mem_write_m,
           valid_m, exec_cnt, squash_cnt
  );
endinterface

// File: rtl/cond_flag_register.sv
// rtl/cond_flag_register.sv - architectural flags, predicated control gating and retire counters
module cond_flag_register #(
  parameter logic [1:0] FLAGA_RST = 2'b00,
  parameter logic [1:0] FLAGB_RST = 2'b00,
  parameter int         CNT_W     = 16
) (
  input logic                clk,
  input logic                reset,
  cond_flag_register_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             live;
  logic             adv;
  logic [1:0]       flag_a_q;
  logic [1:0]       flag_b_q;
  logic             pc_src_m_q;
  logic             reg_write_m_q;
  logic             mem_write_m_q;
  logic             valid_m_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;

  assign live = bus.valid & ~bus.flush;
  assign adv  = live & ~bus.stall;

  // Fetch redirect must see the branch even while this stage is stalled.
  assign bus.pc_src_e = bus.pcs & bus.cond_ex & live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_a_q <= FLAGA_RST;
      flag_b_q <= FLAGB_RST;
    end else if (adv && bus.cond_ex) begin
      if (bus.flag_w[1]) flag_a_q <= bus.alu_flag_a;
      if (bus.flag_w[0]) flag_b_q <= bus.alu_flag_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_src_m_q    <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      valid_m_q     <= 1'b0;
    end else if (bus.flush) begin
      pc_src_m_q    <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
      valid_m_q     <= 1'b0;
    end else if (!bus.stall) begin
      pc_src_m_q    <= bus.pcs   & bus.cond_ex & bus.valid;
      reg_write_m_q <= bus.reg_w & bus.cond_ex & bus.valid;
      mem_write_m_q <= bus.mem_w & bus.cond_ex & bus.valid;
      valid_m_q     <= bus.valid;
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (bus.cnt_clr) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (adv) begin
      if (bus.cond_ex) begin
        if (exec_q != CNT_MAX) exec_q <= exec_q + CNT_ONE;
      end else begin
        if (squash_q != CNT_MAX) squash_q <= squash_q + CNT_ONE;
      end
    end
  end

  assign bus.flag_a      = flag_a_q;
  assign bus.flag_b      = flag_b_q;
  assign bus.pc_src_m    = pc_src_m_q;
  assign bus.reg_write_m = reg_write_m_q;
  assign bus.mem_write_m = mem_write_m_q;
  assign bus.valid_m     = valid_m_q;
  assign bus.exec_cnt    = exec_q;
  assign bus.squash_cnt  = squash_q;
endmodule
